vend_disp_fmt: RTL and testbench



---
 rtl/vend_disp_pkg.sv | 53 +++++
 rtl/bin2bcd_step.sv | 22 ++
 rtl/vend_disp_fmt.sv | 156 +++++++++++++++
 tb/tb_vend_disp_fmt.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_disp_pkg.sv
// Shared constants, types and helpers for the vend_disp_fmt display formatter.
// Optional leading-zero blanking helper is used when VEND_DISP_LZB_EN is defined.
package vend_disp_pkg;

  localparam int VAL_W     = 14;
  localparam int FIELD_DIG = 4;
  localparam int BCD_W     = 4 * FIELD_DIG;
  localparam int CONV_W    = VAL_W + BCD_W;
  localparam int MAX_VAL   = 9999;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] CH_B      = 4'hA;
  localparam logic [3:0] CH_E      = 4'hB;
  localparam logic [3:0] CH_G      = 4'hC;
  localparam logic [3:0] CH_I      = 4'hD;
  localparam logic [3:0] CH_N      = 4'hE;

  localparam logic [1:0] MODE_AMOUNT = 2'd0;
  localparam logic [1:0] MODE_MSG    = 2'd1;
  localparam logic [1:0] MODE_BLANK  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV_L = 2'd1,
    S_CONV_R = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [4*2*FIELD_DIG-1:0] FRAME_BLANK = {(2*FIELD_DIG){DIG_BLANK}};
  localparam logic [4*2*FIELD_DIG-1:0] FRAME_MSG   =
    {DIG_BLANK, DIG_BLANK, DIG_BLANK, CH_B, CH_E, CH_G, CH_I, CH_N};

  function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
    return (v > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : v;
  endfunction

  // Blanks zero digits left of the first non-zero one; the units digit always shows.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = FIELD_DIG - 1; i > 0; i--) begin
      if (lead && bcd[4*i +: 4] == 4'd0) begin
        res[4*i +: 4] = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
module bin2bcd_step
  import vend_disp_pkg::*;
(
  input  logic [CONV_W-1:0] cur,
  output logic [CONV_W-1:0] nxt
);

  logic [CONV_W-1:0] adj;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    adj = cur;
    for (int i = 0; i < FIELD_DIG; i++) begin
      if (adj[VAL_W + 4*i +: 4] >= 4'd5) begin
        adj[VAL_W + 4*i +: 4] = adj[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
    nxt = adj << 1;
  end

endmodule

// File: rtl/vend_disp_fmt.sv
// Formats paid/change amounts, the BEGIN banner or a blank frame into eight digit codes.
// Define VEND_DISP_LZB_EN to blank leading zeros in each amount field.
module vend_disp_fmt
  import vend_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             upd,
  input  logic [VAL_W-1:0] left_val,
  input  logic [VAL_W-1:0] right_val,
  output logic             busy,
  output logic             done,
  output logic [3:0]       smg7,
  output logic [3:0]       smg6,
  output logic [3:0]       smg5,
  output logic [3:0]       smg4,
  output logic [3:0]       smg3,
  output logic [3:0]       smg2,
  output logic [3:0]       smg1,
  output logic [3:0]       smg0
);

  localparam int CNT_W = $clog2(VAL_W);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CONV_W-1:0]  work;
  logic [CONV_W-1:0]  step_out;
  logic [VAL_W-1:0]   right_lat;
  logic [BCD_W-1:0]   left_bcd;
  logic [BCD_W-1:0]   left_codes;
  logic [BCD_W-1:0]   right_codes;
  logic [8*4-1:0]     frame;
  logic [1:0]         mode_q;
  logic               pending;

  logic               is_amount;
  logic               last_iter;
  logic               start;
  logic               conv_step;
  logic               commit;

  assign is_amount = (mode == MODE_AMOUNT);
  assign last_iter = (cnt == CNT_W'(VAL_W - 1));

  bin2bcd_step u_step (
    .cur (work),
    .nxt (step_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a non-amount mode aborts from any state.
  always_comb begin
    state_nxt = state;
    if (!is_amount) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (upd || pending) state_nxt = S_CONV_L;
        S_CONV_L: if (last_iter)      state_nxt = S_CONV_R;
        S_CONV_R: if (last_iter)      state_nxt = S_COMMIT;
        S_COMMIT:                     state_nxt = S_IDLE;
        default:                      state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / control decode.
  always_comb begin
    start     = 1'b0;
    conv_step = 1'b0;
    commit    = 1'b0;
    busy      = (state != S_IDLE);
    if (is_amount) begin
      start     = (state == S_IDLE) && (upd || pending);
      conv_step = (state == S_CONV_L) || (state == S_CONV_R);
      commit    = (state == S_COMMIT);
    end
  end

`ifdef VEND_DISP_LZB_EN
  assign left_codes  = blank_lz(left_bcd);
  assign right_codes = blank_lz(work[CONV_W-1 -: BCD_W]);
`else
  assign left_codes  = left_bcd;
  assign right_codes = work[CONV_W-1 -: BCD_W];
`endif

  // Conversion datapath and request bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      work      <= '0;
      right_lat <= '0;
      left_bcd  <= '0;
      pending   <= 1'b0;
      done      <= 1'b0;
      mode_q    <= MODE_AMOUNT;
    end else begin
      done   <= commit;
      mode_q <= mode;

      if (!is_amount || start) begin
        pending <= 1'b0;
      end else if (upd && busy) begin
        pending <= 1'b1;
      end

      if (start) begin
        work      <= {{BCD_W{1'b0}}, clamp_val(left_val)};
        right_lat <= clamp_val(right_val);
        cnt       <= '0;
      end else if (conv_step) begin
        if (last_iter) begin
          cnt <= '0;
          if (state == S_CONV_L) begin
            left_bcd <= step_out[CONV_W-1 -: BCD_W];
            work     <= {{BCD_W{1'b0}}, right_lat};
          end else begin
            work <= step_out;
          end
        end else begin
          cnt  <= cnt + 1'b1;
          work <= step_out;
        end
      end
    end
  end

  // Display frame: a message/blank request takes effect one edge after it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= FRAME_BLANK;
    end else if (mode_q == MODE_MSG) begin
      frame <= FRAME_MSG;
    end else if (mode_q != MODE_AMOUNT) begin
      frame <= FRAME_BLANK;
    end else if (commit) begin
      frame <= {left_codes, right_codes};
    end
  end

  assign {smg7, smg6, smg5, smg4, smg3, smg2, smg1, smg0} = frame;

endmodule

// File: tb/tb_vend_disp_fmt.sv
// Self-checking bench for vend_disp_fmt: directed scenarios plus randomized amounts vs. a decimal model.
module tb_vend_disp_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        upd;
  logic [13:0] left_val;
  logic [13:0] right_val;
  logic        busy;
  logic        done;
  logic [3:0]  smg7, smg6, smg5, smg4, smg3, smg2, smg1, smg0;
  logic [31:0] got_frame;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] EXP_BLANK = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_MSG   = 32'hFFFA_BCDE;

  vend_disp_fmt dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .upd       (upd),
    .left_val  (left_val),
    .right_val (right_val),
    .busy      (busy),
    .done      (done),
    .smg7      (smg7),
    .smg6      (smg6),
    .smg5      (smg5),
    .smg4      (smg4),
    .smg3      (smg3),
    .smg2      (smg2),
    .smg1      (smg1),
    .smg0      (smg0)
  );

  always #5 clk = ~clk;

  assign got_frame = {smg7, smg6, smg5, smg4, smg3, smg2, smg1, smg0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal reference: saturate, split into digits, optionally blank leading zeros.
  function automatic logic [15:0] field_codes(input int unsigned v);
    int unsigned s;
    int unsigned pw;
    int unsigned d;
    logic [15:0] res;
    s   = (v > 9999) ? 9999 : v;
    pw  = 1;
    res = '0;
    for (int p = 0; p < 4; p++) begin
      d = (s / pw) % 10;
      res[4*p +: 4] = d[3:0];
`ifdef VEND_DISP_LZB_EN
      if (p > 0 && s < pw) res[4*p +: 4] = 4'hF;
`endif
      pw = pw * 10;
    end
    return res;
  endfunction

  function automatic logic [31:0] frame_of(input int unsigned l, input int unsigned r);
    return {field_codes(l), field_codes(r)};
  endfunction

  // Pulse upd with the given values; returns just after the accepting edge k.
  task automatic start_upd(input string tag, input int unsigned l, input int unsigned r);
    left_val  = l[13:0];
    right_val = r[13:0];
    upd       = 1'b1;
    tick();
    upd = 1'b0;
    check({tag, "_busy_k"}, {30'd0, busy, done}, 32'h2);
  endtask

  // From just after edge k: edges k+1..k+28 stay busy, edge k+29 shows the frame with done.
  task automatic finish_conv(input string tag, input int unsigned l, input int unsigned r,
                             input bit jitter);
    for (int i = 1; i <= 28; i++) begin
      if (jitter) begin
        left_val  = 14'($urandom_range(0, 16383));
        right_val = 14'($urandom_range(0, 16383));
      end
      tick();
      check({tag, "_busy"}, {30'd0, busy, done}, 32'h2);
    end
    tick();
    check({tag, "_done"}, {30'd0, busy, done}, 32'h1);
    check({tag, "_frame"}, got_frame, frame_of(l, r));
    tick();
    check({tag, "_after"}, {30'd0, busy, done}, 32'h0);
    check({tag, "_hold"}, got_frame, frame_of(l, r));
  endtask

  initial begin
    int unsigned bnd[4];
    int unsigned l;
    int unsigned r;
    bnd = '{0, 9999, 10000, 16383};

    rst       = 1'b1;
    mode      = 2'd0;
    upd       = 1'b0;
    left_val  = '0;
    right_val = '0;
    tick();
    tick();
    check("reset_frame", got_frame, EXP_BLANK);
    check("reset_ctrl", {30'd0, busy, done}, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_frame", got_frame, EXP_BLANK);

    // Basic amount and saturation.
    start_upd("amt150", 150, 25);
    finish_conv("amt150", 150, 25, 1'b1);
    start_upd("sat", 16383, 0);
    finish_conv("sat", 16383, 0, 1'b1);

    // Pending: second upd at k+5 merges and restarts after commit with re-sampled values.
    start_upd("pend", 1, 2);
    for (int i = 1; i <= 4; i++) tick();
    left_val  = 14'd7;
    right_val = 14'd8;
    upd       = 1'b1;
    tick();
    upd = 1'b0;
    check("pend_busy_k5", {30'd0, busy, done}, 32'h2);
    for (int i = 6; i <= 28; i++) begin
      tick();
      check("pend_busy1", {30'd0, busy, done}, 32'h2);
    end
    tick();
    check("pend_done1", {30'd0, busy, done}, 32'h1);
    check("pend_frame1", got_frame, frame_of(1, 2));
    tick();
    check("pend_restart", {30'd0, busy, done}, 32'h2);
    for (int i = 31; i <= 58; i++) begin
      tick();
      check("pend_busy2", {30'd0, busy, done}, 32'h2);
    end
    tick();
    check("pend_done2", {30'd0, busy, done}, 32'h1);
    check("pend_frame2", got_frame, frame_of(7, 8));
    for (int i = 0; i < 40; i++) begin
      tick();
      check("pend_no_third", {30'd0, busy, done}, 32'h0);
    end
    check("pend_hold", got_frame, frame_of(7, 8));

    // Abort with MSG at k+10, banner at k+11, held afterwards in AMOUNT without upd.
    start_upd("abort", 3, 4);
    for (int i = 1; i <= 9; i++) tick();
    mode = 2'd1;
    tick();
    check("abort_ctrl", {30'd0, busy, done}, 32'h0);
    mode = 2'd0;
    tick();
    check("abort_msg", got_frame, EXP_MSG);
    check("abort_no_done", {30'd0, busy, done}, 32'h0);
    for (int i = 0; i < 35; i++) begin
      tick();
      check("abort_quiet", {30'd0, busy, done}, 32'h0);
    end
    check("msg_hold", got_frame, EXP_MSG);

    // BLANK via mode 3.
    mode = 2'd3;
    tick();
    mode = 2'd0;
    tick();
    check("blank3_frame", got_frame, EXP_BLANK);

    // upd in the same cycle mode returns from MSG to AMOUNT is accepted.
    mode = 2'd1;
    tick();
    mode = 2'd0;
    start_upd("msg2amt", 0, 9999);
    finish_conv("msg2amt", 0, 9999, 1'b0);

    // BLANK via mode 2.
    mode = 2'd2;
    tick();
    mode = 2'd0;
    tick();
    check("blank2_frame", got_frame, EXP_BLANK);

    // Reset at k+20 restores blank frame; a fresh conversion then completes normally.
    start_upd("rstmid", 1234, 5678);
    for (int i = 1; i <= 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_frame", got_frame, EXP_BLANK);
    check("rstmid_ctrl", {30'd0, busy, done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_idle", {30'd0, busy, done}, 32'h0);
    end
    start_upd("fresh", 4321, 8765);
    finish_conv("fresh", 4321, 8765, 1'b1);

    // Randomized amounts, with boundary values mixed in.
    for (int n = 0; n < 10; n++) begin
      l = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 3)] : $urandom_range(0, 16383);
      r = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 3)] : $urandom_range(0, 16383);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      start_upd($sformatf("rand%0d", n), l, r);
      finish_conv($sformatf("rand%0d", n), l, r, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
